// File: rtl/keypad_scan_entry.sv
// 4x4 matrix keypad scanner with debounce and a 16-bit hex entry shift register.
// Columns are strobed active-low one at a time; rows are read through a
// 2-flop synchronizer. A key is accepted after DEBOUNCE_SCANS identical
// single-key scans and its code is shifted into the low nibble of value.
module keypad_scan_entry #(
  parameter int unsigned SCAN_TICKS     = 12000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  KEY_ROW,
  output logic [3:0]  KEY_COL,
  input  logic        CLR,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int unsigned TW = $clog2(SCAN_TICKS);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [TW-1:0] tick;
  logic [1:0]    col;
  logic [15:0]   snapshot;
  logic [15:0]   snap_full;
  logic          tick_end;
  logic          scan_end;

  logic [4:0]    hits;
  logic [3:0]    hit_code;
  logic          snap_none;
  logic          snap_single;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cand;
  logic [3:0]    cand_nx;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nx;
  logic          accept;

  assign tick_end = (tick == TW'(SCAN_TICKS - 1));
  assign scan_end = tick_end && (col == 2'd3);
  assign KEY_COL  = ~(4'b0001 << col);
  assign key_held = (state == HELD) || (state == RELEASE);

  // Two-stage synchronizer for the asynchronous row inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= KEY_ROW;
      row_sync <= row_meta;
    end
  end

  // Column strobe sequencer; captures the rows of the active column at its last tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick     <= '0;
      col      <= '0;
      snapshot <= '0;
    end else if (tick_end) begin
      tick                   <= '0;
      col                    <= col + 2'd1;
      snapshot[col*4 +: 4]   <= ~row_sync;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // Full-scan view at scan end: column 3 comes straight from the synchronizer
  // since its snapshot slot is only written on this same edge.
  always_comb begin
    snap_full        = snapshot;
    snap_full[15:12] = ~row_sync;
  end

  // Count pressed keys in the scan and derive the code of the (last) hit.
  // Snapshot index is col*4+row while the key code is row*4+col.
  always_comb begin
    hits     = '0;
    hit_code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (snap_full[i]) begin
        hits     = hits + 5'd1;
        hit_code = {i[1:0], i[3:2]};
      end
    end
    snap_none   = (hits == 5'd0);
    snap_single = (hits == 5'd1);
  end

  // Debounce FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  end

  // Debounce FSM next-state logic, evaluated only at scan end.
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    accept   = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (snap_single) begin
            state_nx = DEBOUNCE;
            cand_nx  = hit_code;
            cnt_nx   = 4'd1;
          end
        end
        DEBOUNCE: begin
          if (snap_single && (hit_code == cand)) begin
            if (cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              accept   = 1'b1;
              state_nx = HELD;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 4'd1;
            end
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        HELD: begin
          if (snap_none) begin
            state_nx = RELEASE;
            cnt_nx   = 4'd1;
          end
        end
        RELEASE: begin
          if (snap_none) begin
            if (cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 4'd1;
            end
          end else begin
            state_nx = HELD;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Entry register and key outputs; CLR together with an accept clears then shifts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      value     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand;
        value    <= {(CLR ? 12'h000 : value[11:0]), cand};
      end else if (CLR) begin
        value <= '0;
      end
    end
  end

endmodule
